temp_sensor_ctrl: RTL and testbench
===================================

Name: temp_sensor_ctrl

Overview:
Conversion sequencer for the temperature sensor macro. It enables the analog core and gives it time to settle. It then pulses the counter reset, waits for the sensor's DONE, and captures DOUT. Optionally it averages 2^N conversions, re-arms periodically, and flags timeouts. It sits between the register/bus interface and the sensor macro, in the CLK_REF domain.

Parameters:
SETTLE_CYC, 64, CLK_REF cycles with sensor enable high before the first counter reset of a burst
RST_CYC, 4, CLK_REF cycles RESET_COUNTERn is held low before each conversion
TIMEOUT_W, 20, width of conversion timeout counter; timeout at 2^TIMEOUT_W-1 cycles
PERIOD_W, 16, width of the periodic-mode interval register

Ports:
CLK_REF  input  1  reference clock, also clocks the sensor macro
RESETn  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse: begin one measurement (burst of 2^avg_log2 conversions)
periodic  input  1  level: re-launch a measurement every period_cyc cycles after each completion
period_cyc  input  PERIOD_W  idle gap between periodic measurements, in cycles; 0 treated as 1
avg_log2  input  2  number of conversions averaged = 1,2,4,8
sel_conv_time_cfg  input  4  conversion time select forwarded to sensor
abort  input  1  level: return to IDLE, sensor disabled
sens_done  input  1  sensor DONE (asynchronous to the controller's view; synchronised internally)
sens_dout  input  24  sensor DOUT, valid while synchronised DONE is high
sens_en  output  1  sensor enable
sens_reset_countern  output  1  sensor RESET_COUNTERn
sens_sel_conv_time  output  4  sensor SEL_CONV_TIME
result  output  24  averaged conversion result
result_valid  output  1  one-cycle pulse when result updates
busy  output  1  high in any state other than IDLE/WAIT
timeout_err  output  1  sticky; cleared by next start
sample_cnt  output  8  count of completed measurements; wraps at 255->0

Behaviour:
- Reset values: sens_en=0, sens_reset_countern=0, sens_sel_conv_time=0, result=0, result_valid=0, busy=0, timeout_err=0, sample_cnt=0, state=IDLE.
- sens_done passes a 2-flop synchroniser followed by rising-edge detect. done_rise is asserted 3 cycles after the sens_done rising edge.
- States: IDLE, SETTLE, RSTCNT, CONV, ACCUM, WAIT.
- IDLE:
  - sens_en=0, sens_reset_countern=0.
  - On start, or on periodic rising edge: latch sel_conv_time_cfg and avg_log2, clear the accumulator and conversion index, clear timeout_err, go to SETTLE.
- SETTLE: sens_en=1. After SETTLE_CYC cycles, go to RSTCNT.
- RSTCNT: sens_reset_countern=0 for RST_CYC cycles, then CONV.
- CONV:
  - sens_reset_countern=1; the timeout counter increments.
  - On done_rise: go to ACCUM.
  - When the timeout counter reaches all-ones: set timeout_err, drop sens_en, go to IDLE. No result_valid is issued.
- ACCUM:
  - acc (27 bits) += sens_dout, sampled this cycle; the index increments.
  - If index < 2^avg_log2: go to RSTCNT (no re-settle).
  - Otherwise: result = acc >> avg_log2 (truncating), pulse result_valid next cycle, increment sample_cnt, then go to WAIT if periodic=1, else IDLE.
- WAIT:
  - sens_en=0; count period_cyc cycles, then SETTLE.
  - If periodic drops, go to IDLE.
- start while busy: ignored.
- abort: from any state, go to IDLE next cycle with sens_en=0. result and sample_cnt are retained. abort has priority over start and done_rise in the same cycle.
- sens_sel_conv_time holds the value latched at burst start for the whole burst. Config changes mid-burst take effect at the next burst.
- A spurious done_rise outside CONV is ignored.
- RESETn assertion mid-operation: all state returns to reset values immediately (asynchronously).

Test Plan:
- Single shot: avg_log2=0, start; sensor model returns DONE 100 cycles after reset release with DOUT=0x000ABC -> sens_en high ~SETTLE_CYC+RST_CYC+103 cycles; result=0x000ABC; one result_valid pulse; sample_cnt=1; returns to IDLE with sens_en=0.
- Averaging: avg_log2=2, DOUT sequence 100,101,102,105 -> RSTCNT pulses 4 times with a single SETTLE; result=102 (408>>2); one result_valid.
- Timeout: TIMEOUT_W=8, sensor never asserts DONE -> timeout_err=1 at 255 CONV cycles; sens_en=0; result unchanged; next start clears timeout_err.
- Periodic: periodic=1, period_cyc=10 -> three results; sens_en low exactly 10 cycles between bursts; sample_cnt=3. Drop periodic during WAIT -> IDLE.
- Abort/priority: abort asserted in the same cycle as done_rise in CONV -> IDLE, no result_valid. start asserted while busy -> no restart.
- Async reset during CONV: RESETn low mid-cycle -> all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/temp_sensor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : temp_sensor_ctrl
//  Purpose  : Conversion sequencer for the temperature sensor macro. Handles
//             enable/settle, counter reset pulses, DONE synchronisation,
//             2^N averaging, periodic re-launch and conversion timeout.
//  Revision : 1.0  initial release
// ============================================================================
module temp_sensor_ctrl #(
   parameter int SETTLE_CYC = 64,
   parameter int RST_CYC    = 4,
   parameter int TIMEOUT_W  = 20,
   parameter int PERIOD_W   = 16
) (
   input  logic                CLK_REF,
   input  logic                RESETn,
   input  logic                start,
   input  logic                periodic,
   input  logic [PERIOD_W-1:0] period_cyc,
   input  logic [1:0]          avg_log2,
   input  logic [3:0]          sel_conv_time_cfg,
   input  logic                abort,
   input  logic                sens_done,
   input  logic [23:0]         sens_dout,
   output logic                sens_en,
   output logic                sens_reset_countern,
   output logic [3:0]          sens_sel_conv_time,
   output logic [23:0]         result,
   output logic                result_valid,
   output logic                busy,
   output logic                timeout_err,
   output logic [7:0]          sample_cnt
);

   // One shared down-time counter serves SETTLE, RSTCNT and WAIT, so it must
   // be wide enough for the largest of the three intervals.
   localparam int SETTLE_W = $clog2(SETTLE_CYC + 1);
   localparam int RST_W    = $clog2(RST_CYC + 1);
   localparam int CNT_A    = (SETTLE_W > RST_W) ? SETTLE_W : RST_W;
   localparam int CNT_W    = (CNT_A > PERIOD_W) ? CNT_A : PERIOD_W;

   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYC - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SETTLE = 3'd1,
      RSTCNT = 3'd2,
      CONV   = 3'd3,
      ACCUM  = 3'd4,
      WAIT   = 3'd5
   } state_t;

   state_t               state;
   logic                 done_s1;
   logic                 done_s2;
   logic                 done_s3;
   logic                 done_rise;
   logic                 periodic_d;
   logic [1:0]           avg_lat;
   logic [CNT_W-1:0]     cnt;
   logic [TIMEOUT_W-1:0] tcnt;
   logic [26:0]          acc;
   logic [3:0]           idx;

   logic                 launch_req;
   logic                 launch;
   logic [26:0]          acc_sum;
   logic [3:0]           idx_next;
   logic [3:0]           conv_total;
   logic [TIMEOUT_W-1:0] tcnt_next;
   logic [CNT_W-1:0]     period_last;

   // A new burst is requested by a start pulse or by periodic going high.
   assign launch_req  = start | (periodic & ~periodic_d);
   // A zero period behaves as a one-cycle gap.
   assign period_last = (period_cyc == '0) ? '0 : CNT_W'(period_cyc - 1'b1);
   assign launch      = ((state == IDLE) && launch_req) ||
                        ((state == WAIT) && periodic && (cnt == period_last));
   assign acc_sum     = acc + {3'b000, sens_dout};
   assign idx_next    = idx + 4'd1;
   assign conv_total  = 4'd1 << avg_lat;
   assign tcnt_next   = tcnt + 1'b1;

   // Two-flop DONE synchroniser plus registered rising-edge detect.
   always_ff @(posedge CLK_REF or negedge RESETn) begin
      if (!RESETn) begin
         done_s1   <= 1'b0;
         done_s2   <= 1'b0;
         done_s3   <= 1'b0;
         done_rise <= 1'b0;
      end else begin
         done_s1   <= sens_done;
         done_s2   <= done_s1;
         done_s3   <= done_s2;
         done_rise <= done_s2 & ~done_s3;
      end
   end

   // Delayed copy of periodic for edge detection.
   always_ff @(posedge CLK_REF or negedge RESETn) begin
      if (!RESETn) begin
         periodic_d <= 1'b0;
      end else begin
         periodic_d <= periodic;
      end
   end

   // Sequencer: state, counters, accumulator and all registered outputs.
   always_ff @(posedge CLK_REF or negedge RESETn) begin
      if (!RESETn) begin
         state               <= IDLE;
         sens_en             <= 1'b0;
         sens_reset_countern <= 1'b0;
         sens_sel_conv_time  <= 4'd0;
         result              <= 24'd0;
         result_valid        <= 1'b0;
         busy                <= 1'b0;
         timeout_err         <= 1'b0;
         sample_cnt          <= 8'd0;
         avg_lat             <= 2'd0;
         cnt                 <= '0;
         tcnt                <= '0;
         acc                 <= 27'd0;
         idx                 <= 4'd0;
      end else begin
         result_valid <= 1'b0;
         if (abort) begin
            // Abort wins over start, done_rise and every other transition.
            state               <= IDLE;
            sens_en             <= 1'b0;
            sens_reset_countern <= 1'b0;
            busy                <= 1'b0;
         end else if (launch) begin
            // Burst start: freeze the configuration for the whole burst.
            sens_sel_conv_time <= sel_conv_time_cfg;
            avg_lat            <= avg_log2;
            acc                <= 27'd0;
            idx                <= 4'd0;
            timeout_err        <= 1'b0;
            cnt                <= '0;
            sens_en            <= 1'b1;
            busy               <= 1'b1;
            state              <= SETTLE;
         end else begin
            case (state)
               IDLE: begin
                  sens_en             <= 1'b0;
                  sens_reset_countern <= 1'b0;
               end
               SETTLE: begin
                  if (cnt == SETTLE_LAST) begin
                     cnt   <= '0;
                     state <= RSTCNT;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               RSTCNT: begin
                  if (cnt == RST_LAST) begin
                     sens_reset_countern <= 1'b1;
                     tcnt                <= '0;
                     state               <= CONV;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               CONV: begin
                  tcnt <= tcnt_next;
                  if (done_rise) begin
                     state <= ACCUM;
                  end else if (&tcnt_next) begin
                     timeout_err         <= 1'b1;
                     sens_en             <= 1'b0;
                     sens_reset_countern <= 1'b0;
                     busy                <= 1'b0;
                     state               <= IDLE;
                  end
               end
               ACCUM: begin
                  acc                 <= acc_sum;
                  idx                 <= idx_next;
                  sens_reset_countern <= 1'b0;
                  cnt                 <= '0;
                  if (idx_next < conv_total) begin
                     state <= RSTCNT;
                  end else begin
                     result       <= 24'(acc_sum >> avg_lat);
                     result_valid <= 1'b1;
                     sample_cnt   <= sample_cnt + 8'd1;
                     sens_en      <= 1'b0;
                     busy         <= 1'b0;
                     state        <= periodic ? WAIT : IDLE;
                  end
               end
               WAIT: begin
                  if (!periodic) begin
                     state <= IDLE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: begin
                  state <= IDLE;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_temp_sensor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_temp_sensor_ctrl
//  Purpose  : Directed self-checking bench for temp_sensor_ctrl with a
//             behavioural sensor macro model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_temp_sensor_ctrl;

   localparam int SETTLE_CYC = 16;
   localparam int RST_CYC    = 4;
   localparam int TIMEOUT_W  = 8;
   localparam int PERIOD_W   = 16;

   logic                CLK_REF = 1'b0;
   logic                RESETn;
   logic                start;
   logic                periodic;
   logic [PERIOD_W-1:0] period_cyc;
   logic [1:0]          avg_log2;
   logic [3:0]          sel_conv_time_cfg;
   logic                abort;
   logic                sens_done;
   logic [23:0]         sens_dout;
   logic                sens_en;
   logic                sens_reset_countern;
   logic [3:0]          sens_sel_conv_time;
   logic [23:0]         result;
   logic                result_valid;
   logic                busy;
   logic                timeout_err;
   logic [7:0]          sample_cnt;

   temp_sensor_ctrl #(
      .SETTLE_CYC (SETTLE_CYC),
      .RST_CYC    (RST_CYC),
      .TIMEOUT_W  (TIMEOUT_W),
      .PERIOD_W   (PERIOD_W)
   ) dut (
      .CLK_REF             (CLK_REF),
      .RESETn              (RESETn),
      .start               (start),
      .periodic            (periodic),
      .period_cyc          (period_cyc),
      .avg_log2            (avg_log2),
      .sel_conv_time_cfg   (sel_conv_time_cfg),
      .abort               (abort),
      .sens_done           (sens_done),
      .sens_dout           (sens_dout),
      .sens_en             (sens_en),
      .sens_reset_countern (sens_reset_countern),
      .sens_sel_conv_time  (sens_sel_conv_time),
      .result              (result),
      .result_valid        (result_valid),
      .busy                (busy),
      .timeout_err         (timeout_err),
      .sample_cnt          (sample_cnt)
   );

   always #5 CLK_REF = ~CLK_REF;

   int n_vec = 0;
   int n_bad = 0;

   // Sensor model controls
   logic        sensor_on  = 1'b0;
   int          conv_delay = 100;
   logic [23:0] dout_q [0:7];
   int          dout_idx   = 0;
   int          ccnt       = 0;

   // Monitor counters
   int   rv_count     = 0;
   int   settle_count = 0;
   int   conv_count   = 0;
   int   en_cycles    = 0;
   int   rcn_cycles   = 0;
   int   low_run      = 0;
   int   last_gap     = 0;
   logic [3:0] conv_sel = 4'd0;
   logic en_prev  = 1'b0;
   logic rcn_prev = 1'b0;

   // Sensor macro: DONE rises conv_delay cycles after RESET_COUNTERn release.
   always @(negedge CLK_REF) begin
      if (!sens_reset_countern) begin
         sens_done = 1'b0;
         ccnt      = 0;
      end else if (sensor_on) begin
         ccnt = ccnt + 1;
         if (ccnt == conv_delay) begin
            sens_dout = dout_q[dout_idx & 7];
            sens_done = 1'b1;
            dout_idx  = dout_idx + 1;
         end
      end
   end

   // Output monitor sampled on the inactive edge.
   always @(negedge CLK_REF) begin
      if (result_valid) rv_count = rv_count + 1;
      if (sens_en && !en_prev) begin
         settle_count = settle_count + 1;
         last_gap     = low_run;
      end
      if (!sens_en) low_run = low_run + 1;
      else          low_run = 0;
      if (sens_en) en_cycles = en_cycles + 1;
      if (sens_reset_countern) rcn_cycles = rcn_cycles + 1;
      if (sens_reset_countern && !rcn_prev) begin
         conv_count = conv_count + 1;
         conv_sel   = sens_sel_conv_time;
      end
      en_prev  = sens_en;
      rcn_prev = sens_reset_countern;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec = n_vec + 1;
      if (got !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK_REF);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int max);
      int k;
      k = 0;
      while (busy && k < max) begin
         tick(1);
         k++;
      end
      check(tag, {31'd0, busy}, 32'd0);
   endtask

   int rv0, s0, c0, k;

   initial begin
      RESETn            = 1'b0;
      start             = 1'b0;
      periodic          = 1'b0;
      period_cyc        = 16'd10;
      avg_log2          = 2'd0;
      sel_conv_time_cfg = 4'd0;
      abort             = 1'b0;
      sens_done         = 1'b0;
      sens_dout         = 24'd0;
      for (int i = 0; i < 8; i++) dout_q[i] = 24'd0;

      // Reset state
      tick(3);
      check("rst_sens_en",  {31'd0, sens_en}, 32'd0);
      check("rst_rcn",      {31'd0, sens_reset_countern}, 32'd0);
      check("rst_result",   {8'd0, result}, 32'd0);
      check("rst_busy",     {31'd0, busy}, 32'd0);
      check("rst_tmo",      {31'd0, timeout_err}, 32'd0);
      check("rst_samples",  {24'd0, sample_cnt}, 32'd0);
      RESETn = 1'b1;
      tick(2);

      // Single shot, 100-cycle conversion, config changed mid-burst
      sensor_on = 1'b1; conv_delay = 100; dout_idx = 0; dout_q[0] = 24'h000ABC;
      avg_log2 = 2'd0; sel_conv_time_cfg = 4'h5;
      en_cycles = 0; rcn_cycles = 0; rv0 = rv_count; s0 = settle_count; c0 = conv_count;
      pulse_start();
      sel_conv_time_cfg = 4'hA;
      check("single_busy", {31'd0, busy}, 32'd1);
      check("single_sel",  {28'd0, sens_sel_conv_time}, 32'h5);
      wait_idle("single_wait", 400);
      tick(2);
      check("single_result",  {8'd0, result}, 32'h000ABC);
      check("single_rv",      rv_count - rv0, 32'd1);
      check("single_samples", {24'd0, sample_cnt}, 32'd1);
      check("single_en_off",  {31'd0, sens_en}, 32'd0);
      check("single_en_cyc",  en_cycles, SETTLE_CYC + RST_CYC + 104);
      check("single_rcn_cyc", rcn_cycles, 32'd104);
      check("single_conv_sel", {28'd0, conv_sel}, 32'h5);

      // Averaging over four conversions
      conv_delay = 5; dout_idx = 0;
      dout_q[0] = 24'd100; dout_q[1] = 24'd101; dout_q[2] = 24'd102; dout_q[3] = 24'd105;
      avg_log2 = 2'd2;
      rv0 = rv_count; s0 = settle_count; c0 = conv_count;
      pulse_start();
      wait_idle("avg_wait", 600);
      tick(2);
      check("avg_result",  {8'd0, result}, 32'd102);
      check("avg_rv",      rv_count - rv0, 32'd1);
      check("avg_settles", settle_count - s0, 32'd1);
      check("avg_convs",   conv_count - c0, 32'd4);
      check("avg_samples", {24'd0, sample_cnt}, 32'd2);

      // Timeout: sensor never answers
      sensor_on = 1'b0; avg_log2 = 2'd0;
      rv0 = rv_count; rcn_cycles = 0;
      pulse_start();
      wait_idle("tmo_wait", 600);
      tick(2);
      check("tmo_flag",    {31'd0, timeout_err}, 32'd1);
      check("tmo_cycles",  rcn_cycles, 32'd255);
      check("tmo_en_off",  {31'd0, sens_en}, 32'd0);
      check("tmo_result",  {8'd0, result}, 32'd102);
      check("tmo_rv",      rv_count - rv0, 32'd0);
      check("tmo_samples", {24'd0, sample_cnt}, 32'd2);
      pulse_start();
      check("tmo_cleared", {31'd0, timeout_err}, 32'd0);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_en",   {31'd0, sens_en}, 32'd0);

      // start while busy is ignored
      sensor_on = 1'b1; conv_delay = 20; dout_idx = 0; dout_q[0] = 24'h123456;
      rv0 = rv_count; s0 = settle_count; c0 = conv_count;
      pulse_start();
      tick(5);
      pulse_start();
      wait_idle("busy_wait", 400);
      tick(2);
      check("busy_settles", settle_count - s0, 32'd1);
      check("busy_convs",   conv_count - c0, 32'd1);
      check("busy_rv",      rv_count - rv0, 32'd1);
      check("busy_result",  {8'd0, result}, 32'h123456);
      check("busy_samples", {24'd0, sample_cnt}, 32'd3);

      // abort in the same cycle as done_rise
      conv_delay = 10; dout_idx = 0; dout_q[0] = 24'h000777;
      rv0 = rv_count;
      pulse_start();
      k = 0;
      while (!sens_done && k < 200) begin
         tick(1);
         k++;
      end
      check("prio_done_seen", {31'd0, sens_done}, 32'd1);
      tick(2);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check("prio_busy", {31'd0, busy}, 32'd0);
      check("prio_en",   {31'd0, sens_en}, 32'd0);
      tick(5);
      check("prio_rv",      rv_count - rv0, 32'd0);
      check("prio_result",  {8'd0, result}, 32'h123456);
      check("prio_samples", {24'd0, sample_cnt}, 32'd3);

      // Periodic: three bursts, 10-cycle gap, then drop periodic in WAIT
      conv_delay = 5; dout_idx = 0;
      dout_q[0] = 24'd7; dout_q[1] = 24'd8; dout_q[2] = 24'd9; dout_q[3] = 24'd10;
      avg_log2 = 2'd0; period_cyc = 16'd10;
      rv0 = rv_count; s0 = settle_count;
      periodic = 1'b1;
      k = 0;
      while ((rv_count - rv0) < 3 && k < 1000) begin
         tick(1);
         k++;
      end
      periodic = 1'b0;
      tick(30);
      check("per_rv",      rv_count - rv0, 32'd3);
      check("per_settles", settle_count - s0, 32'd3);
      check("per_gap",     last_gap, 32'd10);
      check("per_result",  {8'd0, result}, 32'd9);
      check("per_samples", {24'd0, sample_cnt}, 32'd6);
      check("per_idle",    {31'd0, busy | sens_en}, 32'd0);

      // Asynchronous reset in the middle of a conversion
      conv_delay = 100; sel_conv_time_cfg = 4'h3;
      pulse_start();
      k = 0;
      while (!sens_reset_countern && k < 100) begin
         tick(1);
         k++;
      end
      check("arst_in_conv", {31'd0, sens_reset_countern}, 32'd1);
      tick(1);
      #2;
      RESETn = 1'b0;
      #1;
      check("arst_en",      {31'd0, sens_en}, 32'd0);
      check("arst_rcn",     {31'd0, sens_reset_countern}, 32'd0);
      check("arst_sel",     {28'd0, sens_sel_conv_time}, 32'd0);
      check("arst_busy",    {31'd0, busy}, 32'd0);
      check("arst_result",  {8'd0, result}, 32'd0);
      check("arst_samples", {24'd0, sample_cnt}, 32'd0);
      tick(2);
      RESETn = 1'b1;
      tick(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
